// File: rtl/fault_reg_array.sv
// fault_reg_array: an array of protected target flops loaded with a known
// pattern and compared against that pattern every RUN cycle. Any flipped bit
// is logged (sticky mask, saturating count, first-fault index) and the
// register is rewritten with the expected value on the following cycle.
module fault_reg_array #(
  parameter int N_REGS = 8,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              clear,
  input  logic [N_REGS-1:0] inject,
  output logic [N_REGS-1:0] reg_q,
  output logic              fault,
  output logic [N_REGS-1:0] fault_mask,
  output logic [CNT_W-1:0]  fault_count,
  output logic [IDX_W-1:0]  first_idx,
  output logic              first_valid,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ALL0    = 2'd0;
  localparam logic [1:0] MODE_ALL1    = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_TOGGLE  = 2'd3;

  state_t            state_reg;
  logic [1:0]        mode_l_reg;
  logic              ph_reg;
  // The laser target: these flops must survive synthesis as distinct cells.
  (* keep = "true", dont_touch = "true" *) logic [N_REGS-1:0] reg_q_reg;
  logic              fault_reg;
  logic [N_REGS-1:0] mask_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [IDX_W-1:0]  first_idx_reg;
  logic              first_valid_reg;

  logic [N_REGS-1:0] checker_pat;
  logic [N_REGS-1:0] pat_mode;
  logic [N_REGS-1:0] pat_l;
  logic [N_REGS-1:0] expected;
  logic [N_REGS-1:0] expected_next;
  logic [N_REGS-1:0] mis;
  logic              mis_any;
  logic [IDX_W-1:0]  low_idx;

  // Checkerboard: odd bit positions are 1 (8'hAA for eight registers).
  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_checker
      assign checker_pat[gi] = ((gi % 2) == 1);
    end
  endgenerate

  // Pattern for the live mode input (used while loading) and the latched mode.
  always_comb begin
    pat_mode = '0;
    case (mode)
      MODE_ALL0:    pat_mode = '0;
      MODE_ALL1:    pat_mode = '1;
      MODE_CHECKER: pat_mode = checker_pat;
      MODE_TOGGLE:  pat_mode = checker_pat;
      default:      pat_mode = '0;
    endcase
    pat_l = '0;
    case (mode_l_reg)
      MODE_ALL0:    pat_l = '0;
      MODE_ALL1:    pat_l = '1;
      MODE_CHECKER: pat_l = checker_pat;
      MODE_TOGGLE:  pat_l = checker_pat;
      default:      pat_l = '0;
    endcase
  end

  assign expected      = pat_l ^ {N_REGS{ph_reg}};
  assign expected_next = pat_l ^ {N_REGS{~ph_reg}};
  assign mis           = reg_q_reg ^ expected;
  assign mis_any       = (state_reg == ST_RUN) && (|mis);

  // Lowest set bit of the current mismatch vector.
  always_comb begin
    low_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (mis[i]) low_idx = IDX_W'(i);
    end
  end

  // Sequencer and target registers: load, then rewrite the expected value every RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mode_l_reg <= MODE_ALL0;
      ph_reg     <= 1'b0;
      reg_q_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arm) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          mode_l_reg <= mode;
          ph_reg     <= 1'b0;
          reg_q_reg  <= pat_mode ^ inject;
          state_reg  <= ST_RUN;
        end
        ST_RUN: begin
          if (mode_l_reg == MODE_TOGGLE) begin
            reg_q_reg <= expected_next ^ inject;
            ph_reg    <= ~ph_reg;
          end else begin
            reg_q_reg <= pat_l ^ inject;
          end
          if (!arm) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Fault bookkeeping; a mismatch in the same cycle as clear is logged on top of the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_reg       <= 1'b0;
      mask_reg        <= '0;
      count_reg       <= '0;
      first_idx_reg   <= '0;
      first_valid_reg <= 1'b0;
    end else begin
      fault_reg <= mis_any;
      if (clear) begin
        mask_reg        <= '0;
        count_reg       <= '0;
        first_idx_reg   <= '0;
        first_valid_reg <= 1'b0;
      end
      if (mis_any) begin
        if (clear) begin
          mask_reg        <= mis;
          count_reg       <= CNT_W'(1);
          first_idx_reg   <= low_idx;
          first_valid_reg <= 1'b1;
        end else begin
          mask_reg <= mask_reg | mis;
          if (count_reg != {CNT_W{1'b1}}) count_reg <= count_reg + CNT_W'(1);
          if (!first_valid_reg) begin
            first_idx_reg   <= low_idx;
            first_valid_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign reg_q       = reg_q_reg;
  assign fault       = fault_reg;
  assign fault_mask  = mask_reg;
  assign fault_count = count_reg;
  assign first_idx   = first_idx_reg;
  assign first_valid = first_valid_reg;
  assign state       = state_reg;

endmodule

// File: doc/fault_reg_array.md
Name: fault_reg_array

Overview:
- Parametrised successor to the single-pattern register locator used in laser fault-injection campaigns.
- Holds an array of N_REGS kept/dont_touch flops loaded with a known pattern, then checks them every clock against the expected value.
- Any flipped bit is recorded in a sticky per-register fault mask, a saturating event counter and a first-fault index. The flipped register is rewritten to the expected value on the next cycle.
- Sits between the MMCM clock domain and the host/debug readout logic. The laser target is the reg_q flops.

Parameters:
- N_REGS, 8, number of target registers (>=2).
- CNT_W, 16, width of fault event counter.
- IDX_W, $clog2(N_REGS), width of first-fault index.

Ports:
- clk  in  1  system clock (100 MHz from clock wizard).
- rst_n  in  1  synchronous active-low reset.
- mode  in  2  pattern select: 0 ALL0, 1 ALL1, 2 CHECKER, 3 TOGGLE. Sampled only on LOAD.
- arm  in  1  level. Rising into IDLE starts a run; low during RUN ends it.
- clear  in  1  pulse. Clears fault mask, count and first-fault info.
- inject  in  N_REGS  verification-only bit flips XORed into reg_q next value. Tied 0 in hardware.
- reg_q  out  N_REGS  the target registers (keep/dont_touch, never merged).
- fault  out  1  registered pulse, 1 cycle after a mismatch is seen.
- fault_mask  out  N_REGS  sticky OR of all mismatches since clear.
- fault_count  out  CNT_W  mismatch cycles since clear, saturating.
- first_idx  out  IDX_W  lowest faulted bit index of the first fault since clear.
- first_valid  out  1  first_idx is valid.
- state  out  2  0 IDLE, 1 LOAD, 2 RUN.

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, state IDLE, mode_l=0, ph=0. Reset mid-RUN aborts the run; no fault is recorded that cycle.
- pattern(m): ALL0 = 0; ALL1 = all ones; CHECKER bit i = i[0], so 8'hAA for N=8; TOGGLE base = CHECKER.
- expected = pattern(mode_l) ^ {N_REGS{ph}}.
- IDLE: reg_q holds its value, no checking. arm=1 -> LOAD.
- LOAD (exactly 1 cycle): mode_l<=mode, ph<=0, reg_q<=pattern(mode)^inject. Next state RUN, unconditionally. If arm was dropped, RUN exits on its first cycle.
- RUN, every cycle:
  - mis = reg_q ^ expected.
  - Non-TOGGLE modes: reg_q <= pattern ^ inject, ph stays 0.
  - TOGGLE: reg_q <= expected_next ^ inject, with expected_next = pattern ^ {N{~ph}}, and ph<=~ph.
  - A fault therefore lives exactly one cycle and is counted exactly once.
- If mis!=0 in RUN:
  - fault<=1 next cycle.
  - fault_mask |= mis.
  - fault_count += 1, holding at 2^CNT_W-1.
  - If !first_valid: first_idx <= index of lowest set bit of mis, first_valid<=1.
  - Otherwise fault<=0.
- RUN with arm=0: the compare is still performed that cycle, then the block goes to IDLE and reg_q keeps the last written value.
- clear=1 (any state): mask, count, first_idx and first_valid are reset. If a mismatch occurs in the same cycle, the mismatch is recorded on top of the clear: count=1, mask=mis, first_* from mis.
- inject is only honoured in LOAD/RUN; ignored in IDLE.
- mode changes outside LOAD have no effect.
- Latency: inject in cycle t -> visible on reg_q at t+1 -> fault, mask and count update at t+2.

Test Plan:
- Reset, mode=2, arm=1: LOAD -> reg_q=8'hAA on RUN entry. 100 RUN cycles with inject=0 -> fault never high, count=0, mask=0, first_valid=0.
- mode=1 RUN, inject=8'h10 for 1 cycle -> reg_q=8'hEF for 1 cycle, then 8'hFF. fault pulses once, mask=8'h10, count=1, first_idx=4, first_valid=1.
- mode=3 RUN: reg_q alternates 8'hAA/8'h55 each cycle. Inject 8'h03 then, 5 cycles later, 8'h80 -> count=2, mask=8'h83, first_idx=0 (unchanged by the second fault).
- CNT_W=4, inject 1 bit for 20 consecutive cycles -> count saturates at 15, fault high for 20 cycles.
- Clear in the same cycle a mismatch is seen -> count=1, mask=that mismatch. Clear alone -> all fault status 0.
- rst_n low during RUN with inject active -> next cycle all outputs 0, state IDLE. arm dropped mid-RUN -> IDLE after 1 cycle, reg_q frozen.
